dmem_arbiter: RTL and testbench

- Single-port controller and arbiter in front of the data memory.
- Shares the memory between two requesters:
  - port 0: CPU load/store unit
  - port 1: program loader / debug DMA
- Uses valid/ready request handshakes and a one-cycle response pulse.
- Handles word, half and byte access sizes, alignment and range checks, and load sign/zero extension; drives the memory's 2-bit write-enable encoding.

---
 rtl/dmem_arbiter.sv | 146 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter and access controller for a single-port data memory.
// Each transaction runs IDLE -> ACCESS -> RESP; size, alignment and range are checked in ACCESS.
module dmem_arbiter #(
  parameter int DEPTH = 64,
  parameter int AW    = 32
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          p0_valid,
  output logic          p0_ready,
  input  logic          p0_we,
  input  logic [1:0]    p0_size,
  input  logic          p0_signed,
  input  logic [AW-1:0] p0_addr,
  input  logic [31:0]   p0_wdata,
  output logic          p0_resp_valid,
  output logic [31:0]   p0_resp_rdata,
  output logic          p0_resp_err,
  input  logic          p1_valid,
  output logic          p1_ready,
  input  logic          p1_we,
  input  logic [1:0]    p1_size,
  input  logic          p1_signed,
  input  logic [AW-1:0] p1_addr,
  input  logic [31:0]   p1_wdata,
  output logic          p1_resp_valid,
  output logic [31:0]   p1_resp_rdata,
  output logic          p1_resp_err,
  output logic [AW-1:0] mem_a,
  output logic [31:0]   mem_wd,
  output logic [1:0]    mem_we,
  input  logic [31:0]   mem_rd
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  typedef struct packed {
    logic          we;
    logic [1:0]    size;
    logic          sgn;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
  } req_t;

  localparam logic [AW-1:0] LIMIT = AW'(DEPTH * 4);

  state_t        state, state_nx;
  req_t [1:0]    req;
  req_t          q;
  logic          rr, owner, gnt, hs, acc_err;
  logic [1:0]    valid, ready;
  logic [7:0]    byte_v;
  logic [15:0]   half_v;
  logic [31:0]   acc_rdata, rdata_q;
  logic          err_q;

  assign req[0] = '{we: p0_we, size: p0_size, sgn: p0_signed, addr: p0_addr, wdata: p0_wdata};
  assign req[1] = '{we: p1_we, size: p1_size, sgn: p1_signed, addr: p1_addr, wdata: p1_wdata};
  assign valid  = {p1_valid, p0_valid};

  // rr only breaks ties; a lone requester always wins
  assign gnt = (valid == 2'b11) ? rr : valid[1];

  always_comb begin
    ready = '0;
    if (reset_n && state == IDLE && |valid) ready[gnt] = 1'b1;
  end
  assign p0_ready = ready[0];
  assign p1_ready = ready[1];
  assign hs       = |(ready & valid);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= IDLE;
      rr      <= 1'b0;
      owner   <= 1'b0;
      q       <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= state_nx;
      if (hs) begin
        q     <= req[gnt];
        owner <= gnt;
        rr    <= ~gnt;
      end
      if (state == ACCESS) begin
        rdata_q <= acc_rdata;
        err_q   <= acc_err;
      end
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (hs) state_nx = ACCESS;
      ACCESS:  state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign acc_err = (q.size == 2'b11) ||
                   (q.size == 2'b01 && q.addr[0]) ||
                   (q.size == 2'b00 && q.addr[1:0] != 2'b00) ||
                   (q.addr >= LIMIT);

  assign byte_v = 8'(mem_rd >> {q.addr[1:0], 3'b000});
  assign half_v = q.addr[1] ? mem_rd[31:16] : mem_rd[15:0];

  always_comb begin
    acc_rdata = '0;
    if (!acc_err && !q.we) begin
      case (q.size)
        2'b00:   acc_rdata = mem_rd;
        2'b01:   acc_rdata = {{16{q.sgn & half_v[15]}}, half_v};
        2'b10:   acc_rdata = {{24{q.sgn & byte_v[7]}}, byte_v};
        default: acc_rdata = '0;
      endcase
    end
  end

  // Gating on reset_n keeps a reset during ACCESS from committing the write
  always_comb begin
    mem_a  = '0;
    mem_wd = '0;
    mem_we = 2'b00;
    if (reset_n && state == ACCESS && !acc_err) begin
      mem_a = q.addr;
      if (q.we) begin
        mem_wd = q.wdata;
        case (q.size)
          2'b00:   mem_we = 2'b01;
          2'b01:   mem_we = 2'b10;
          default: mem_we = 2'b11;
        endcase
      end
    end
  end

  assign p0_resp_valid = reset_n && state == RESP && !owner;
  assign p1_resp_valid = reset_n && state == RESP && owner;
  assign p0_resp_rdata = p0_resp_valid ? rdata_q : '0;
  assign p1_resp_rdata = p1_resp_valid ? rdata_q : '0;
  assign p0_resp_err   = p0_resp_valid & err_q;
  assign p1_resp_err   = p1_resp_valid & err_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural byte-lane memory.
module tb_dmem_arbiter;
  localparam int DEPTH = 64;
  localparam int AW    = 32;

  logic          clk = 1'b0, reset_n = 1'b0;
  logic          p0_valid = 0, p0_we = 0, p0_signed = 0;
  logic [1:0]    p0_size = 0;
  logic [AW-1:0] p0_addr = 0;
  logic [31:0]   p0_wdata = 0;
  logic          p1_valid = 0, p1_we = 0, p1_signed = 0;
  logic [1:0]    p1_size = 0;
  logic [AW-1:0] p1_addr = 0;
  logic [31:0]   p1_wdata = 0;
  logic          p0_ready, p0_resp_valid, p0_resp_err;
  logic          p1_ready, p1_resp_valid, p1_resp_err;
  logic [31:0]   p0_resp_rdata, p1_resp_rdata;
  logic [AW-1:0] mem_a;
  logic [31:0]   mem_wd, mem_rd;
  logic [1:0]    mem_we;

  int tests = 0, fails = 0;

  dmem_arbiter #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .reset_n(reset_n),
    .p0_valid(p0_valid), .p0_ready(p0_ready), .p0_we(p0_we), .p0_size(p0_size),
    .p0_signed(p0_signed), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_resp_valid(p0_resp_valid), .p0_resp_rdata(p0_resp_rdata), .p0_resp_err(p0_resp_err),
    .p1_valid(p1_valid), .p1_ready(p1_ready), .p1_we(p1_we), .p1_size(p1_size),
    .p1_signed(p1_signed), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_resp_valid(p1_resp_valid), .p1_resp_rdata(p1_resp_rdata), .p1_resp_err(p1_resp_err),
    .mem_a(mem_a), .mem_wd(mem_wd), .mem_we(mem_we), .mem_rd(mem_rd)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:DEPTH-1] = '{default: 32'h0};
  assign mem_rd = mem[mem_a[7:2]];
  always @(posedge clk) begin
    case (mem_we)
      2'b01: mem[mem_a[7:2]] <= mem_wd;
      2'b10: if (mem_a[1]) mem[mem_a[7:2]][31:16] <= mem_wd[15:0];
             else          mem[mem_a[7:2]][15:0]  <= mem_wd[15:0];
      2'b11: case (mem_a[1:0])
               2'd0: mem[mem_a[7:2]][7:0]   <= mem_wd[7:0];
               2'd1: mem[mem_a[7:2]][15:8]  <= mem_wd[7:0];
               2'd2: mem[mem_a[7:2]][23:16] <= mem_wd[7:0];
               2'd3: mem[mem_a[7:2]][31:24] <= mem_wd[7:0];
               default: ;
             endcase
      default: ;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one request on a single port and check accept, ACCESS and RESP cycles.
  // Entry and exit: #1 after a rising edge with the DUT idle.
  task automatic do_req(input string tag, input bit port, input logic we, input logic [1:0] size,
                        input logic sgn, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input logic exp_err, input logic [1:0] exp_we);
    int w = 0;
    if (port) begin
      p1_we = we; p1_size = size; p1_signed = sgn; p1_addr = addr; p1_wdata = wd; p1_valid = 1;
    end else begin
      p0_we = we; p0_size = size; p0_signed = sgn; p0_addr = addr; p0_wdata = wd; p0_valid = 1;
    end
    #0;
    while (!(port ? p1_ready : p0_ready) && w < 20) begin
      @(posedge clk); #1; w++;
    end
    chk({tag, "_ready_wait"}, w, 0);
    chk({tag, "_ready_other"}, port ? p0_ready : p1_ready, 0);
    @(posedge clk); #1;
    p0_valid = 0; p1_valid = 0;
    chk({tag, "_access_we"}, mem_we, exp_we);
    chk({tag, "_access_noresp"}, p0_resp_valid | p1_resp_valid, 0);
    @(posedge clk); #1;
    chk({tag, "_resp_valid"}, port ? p1_resp_valid : p0_resp_valid, 1);
    chk({tag, "_resp_other"}, port ? p0_resp_valid : p1_resp_valid, 0);
    chk({tag, "_rdata"}, port ? p1_resp_rdata : p0_resp_rdata, exp_rd);
    chk({tag, "_err"}, port ? p1_resp_err : p0_resp_err, exp_err);
    chk({tag, "_resp_we"}, mem_we, 0);
    @(posedge clk); #1;
    chk({tag, "_pulse_end"}, p0_resp_valid | p1_resp_valid, 0);
  endtask

  initial begin
    int g, r0, r1, n0, n1, cyc;
    bit exp_g;

    // Reset with a request pending: nothing may be granted
    p0_valid = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_p0_ready", p0_ready, 0);
    chk("rst_p1_ready", p1_ready, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_a", mem_a, 0);
    chk("rst_mem_wd", mem_wd, 0);
    chk("rst_resp_valid", {p0_resp_valid, p1_resp_valid}, 0);
    chk("rst_resp_err", {p0_resp_err, p1_resp_err}, 0);
    chk("rst_rdata", p0_resp_rdata | p1_resp_rdata, 0);
    p0_valid = 0;
    reset_n = 1;
    @(posedge clk); #1;

    do_req("sw10",   0, 1, 2'b00, 0, 32'h10, 32'hDEADBEEF, 32'h0,        0, 2'b01);
    do_req("lw10",   0, 0, 2'b00, 0, 32'h10, 32'h0,        32'hDEADBEEF, 0, 2'b00);
    do_req("sw10b",  0, 1, 2'b00, 0, 32'h10, 32'h80FF7F01, 32'h0,        0, 2'b01);
    do_req("lb13s",  0, 0, 2'b10, 1, 32'h13, 32'h0,        32'hFFFFFF80, 0, 2'b00);
    do_req("lb12u",  0, 0, 2'b10, 0, 32'h12, 32'h0,        32'h000000FF, 0, 2'b00);
    do_req("lh10s",  0, 0, 2'b01, 1, 32'h10, 32'h0,        32'h00007F01, 0, 2'b00);
    do_req("lh12s",  1, 0, 2'b01, 1, 32'h12, 32'h0,        32'hFFFF80FF, 0, 2'b00);
    do_req("sh22",   0, 1, 2'b01, 0, 32'h22, 32'h1234ABCD, 32'h0,        0, 2'b10);
    do_req("sb21",   1, 1, 2'b10, 0, 32'h21, 32'h00000055, 32'h0,        0, 2'b11);
    do_req("lw20",   0, 0, 2'b00, 0, 32'h20, 32'h0,        32'hABCD5500, 0, 2'b00);
    do_req("e_sh21", 0, 1, 2'b01, 0, 32'h21, 32'hFFFFFFFF, 32'h0,        1, 2'b00);
    do_req("e_lw22", 1, 0, 2'b00, 0, 32'h22, 32'h0,        32'h0,        1, 2'b00);
    do_req("e_sz11", 0, 1, 2'b11, 0, 32'h20, 32'hFFFFFFFF, 32'h0,        1, 2'b00);
    do_req("e_l100", 0, 0, 2'b00, 0, 32'h100, 32'h0,       32'h0,        1, 2'b00);
    do_req("lw20_k", 0, 0, 2'b00, 0, 32'h20, 32'h0,        32'hABCD5500, 0, 2'b00);

    // Contention: last grant went to p0, so p1 wins the first tie
    p0_we = 0; p0_size = 2'b00; p0_signed = 0; p0_addr = 32'h10; p0_valid = 1;
    p1_we = 0; p1_size = 2'b00; p1_signed = 0; p1_addr = 32'h20; p1_valid = 1;
    g = 0; r0 = 0; r1 = 0; n0 = 0; n1 = 0; cyc = 0;
    #0;
    while ((r0 < 4 || r1 < 4) && cyc < 100) begin
      if (n0 >= 4) p0_valid = 0;
      if (n1 >= 4) p1_valid = 0;
      #0;
      chk("cont_both_ready", p0_ready & p1_ready, 0);
      if (p0_resp_valid) begin
        r0++;
        chk("cont_p0_excl", p1_resp_valid, 0);
        chk("cont_p0_rdata", p0_resp_rdata, 32'h80FF7F01);
      end
      if (p1_resp_valid) begin
        r1++;
        chk("cont_p1_rdata", p1_resp_rdata, 32'hABCD5500);
      end
      if (p0_ready | p1_ready) begin
        exp_g = (g % 2 == 0);
        chk("cont_grant", p1_ready, exp_g);
        g++;
        if (p0_ready) n0++; else n1++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    chk("cont_done_r0", r0, 4);
    chk("cont_done_r1", r1, 4);
    chk("cont_grants", g, 8);
    p0_valid = 0; p1_valid = 0;
    @(posedge clk); #1;

    // Reset during ACCESS of a p1 store: no write, no response
    p1_we = 1; p1_size = 2'b00; p1_signed = 0; p1_addr = 32'h30; p1_wdata = 32'h12345678; p1_valid = 1;
    #0;
    chk("rstx_p1_ready", p1_ready, 1);
    @(posedge clk); #1;
    reset_n = 0; p1_valid = 0;
    #0;
    chk("rstx_access_we", mem_we, 0);
    @(posedge clk); #1;
    chk("rstx_no_resp", p1_resp_valid, 0);
    reset_n = 1;
    @(posedge clk); #1;
    chk("rstx_no_resp2", p1_resp_valid | p0_resp_valid, 0);
    p0_we = 0; p0_size = 2'b00; p0_addr = 32'h30; p0_valid = 1;
    p1_we = 0; p1_size = 2'b00; p1_addr = 32'h10; p1_valid = 1;
    #0;
    chk("rstx_grant_p0", p0_ready, 1);
    chk("rstx_grant_not_p1", p1_ready, 0);
    @(posedge clk); #1;
    p0_valid = 0; p1_valid = 0;
    @(posedge clk); #1;
    chk("rstx_lw30_valid", p0_resp_valid, 1);
    chk("rstx_lw30_rdata", p0_resp_rdata, 32'h0);
    @(posedge clk); #1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
